// File: rtl/rr_mux_scheduler.sv
// rtl/rr_mux_scheduler.sv - round-robin 8:1 bit-select scheduler with valid/ready output stream
module rr_mux_scheduler #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] data_in,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       out_valid,
  output logic       out_data,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] CNT_LAST = 4'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] grant_q, grant_d;
  logic [3:0] cnt_q, cnt_d;

  logic [2:0] pick;
  logic [2:0] idx;
  logic       found;
  logic       xfer;

  // First requesting index in rotating order ptr, ptr+1, ... (3-bit wrap).
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign busy      = (state_q == GRANT);
  assign out_valid = busy & req[sel_q];
  assign xfer      = out_valid & out_ready;
  assign out_data  = data_in[sel_q];
  assign sel       = sel_q;
  assign grant     = grant_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (found) begin
          sel_d   = pick;
          grant_d = 8'h01 << pick;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) cnt_d = cnt_q + 4'd1;
        // Tenure ends when the owner withdraws or its last allowed transfer completes.
        if (!req[sel_q] || (xfer && cnt_q == CNT_LAST)) begin
          ptr_d   = sel_q + 3'd1;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
